// File: rtl/scan_sequencer_3bit.sv
// Scan controller that drives a 3-to-8 active-low decoder: blank, then dwell, per enabled position.
// Optional descending scan with a dir input when SCAN_REVERSE_EN is defined.
module scan_sequencer_3bit #(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int NUM_DIGITS   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] digit_mask,
`ifdef SCAN_REVERSE_EN
  input  logic       dir,
`endif
  output logic [2:0] sel,
  output logic       enable_n,
  output logic       frame_done,
  output logic       busy
);

  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [7:0] NMASK = 8'((32'd1 << NUM_DIGITS) - 32'd1);

  typedef enum logic [1:0] {IDLE, BLANK, ACTIVE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            en_n_q, en_n_d;
  logic            fd_q, fd_d;
  logic            busy_q, busy_d;

  logic [7:0]      em;
  logic [2:0]      lo, hi, up, first, nxt, last;
`ifdef SCAN_REVERSE_EN
  logic [2:0]      dn;
`endif

  // Position search over the effective mask: lowest/highest set index and the
  // next set index above (or below) the current one, with wrap.
  always_comb begin
    em = digit_mask & NMASK;
    lo = '0;
    hi = '0;
    for (int i = 7; i >= 0; i--) if (em[i]) lo = 3'(i);
    for (int i = 0; i < 8; i++)  if (em[i]) hi = 3'(i);
    up = lo;
    for (int i = 7; i >= 0; i--) if (em[i] && (i > int'(sel_q))) up = 3'(i);
`ifdef SCAN_REVERSE_EN
    dn = hi;
    for (int i = 0; i < 8; i++)  if (em[i] && (i < int'(sel_q))) dn = 3'(i);
    first = dir ? hi : lo;
    nxt   = dir ? dn : up;
    last  = dir ? lo : hi;
`else
    first = lo;
    nxt   = up;
    last  = hi;
`endif
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    fd_d    = 1'b0;
    cnt_d   = (cnt_q == CW'(MAXC)) ? cnt_q : cnt_q + 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (run && (em != 8'd0)) begin
          state_d = BLANK;
          sel_d   = first;
        end
      end
      BLANK: begin
        if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end
      end
      ACTIVE: begin
        if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
          // Mask, run and dir are only looked at on this boundary cycle.
          fd_d  = (em != 8'd0) && (sel_q == last);
          cnt_d = '0;
          if (!run || (em == 8'd0)) begin
            state_d = IDLE;
          end else begin
            state_d = BLANK;
            sel_d   = nxt;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    en_n_d = (state_d != ACTIVE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      en_n_q  <= 1'b1;
      fd_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      en_n_q  <= en_n_d;
      fd_q    <= fd_d;
      busy_q  <= busy_d;
    end
  end

  assign sel        = sel_q;
  assign enable_n   = en_n_q;
  assign frame_done = fd_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_scan_sequencer_3bit.sv
// Randomized scoreboard bench: two instances (8 and 5 digits) share stimulus and
// are checked every cycle against a position-plan reference model.
module tb_scan_sequencer_3bit;

  localparam int B = 2;
  localparam int D = 4;
  localparam int P = B + D;

  typedef struct packed {
    logic [2:0] sel;
    logic       en_n;
    logic       fd;
    logic       busy;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [7:0] digit_mask = 8'h00;
  logic       dir = 1'b0;

  logic [2:0] sel8, sel5;
  logic       en8, en5, fd8, fd5, busy8, busy5;

  exp_t q8[$];
  exp_t q5[$];
  int   left [2];
  int   pos  [2];
  bit   scan [2];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  scan_sequencer_3bit #(.DWELL_CYCLES(D), .BLANK_CYCLES(B), .NUM_DIGITS(8)) u8 (
    .clk(clk), .reset(reset), .run(run), .digit_mask(digit_mask),
`ifdef SCAN_REVERSE_EN
    .dir(dir),
`endif
    .sel(sel8), .enable_n(en8), .frame_done(fd8), .busy(busy8));

  scan_sequencer_3bit #(.DWELL_CYCLES(D), .BLANK_CYCLES(B), .NUM_DIGITS(5)) u5 (
    .clk(clk), .reset(reset), .run(run), .digit_mask(digit_mask),
`ifdef SCAN_REVERSE_EN
    .dir(dir),
`endif
    .sel(sel5), .enable_n(en5), .frame_done(fd5), .busy(busy5));

  // First position of a frame in scan order; with d flipped it is the frame's last.
  function automatic int first_pos(input logic [7:0] em, input int n, input bit d);
    for (int k = 0; k < n; k++) begin
      int c;
      c = d ? (n - 1 - k) : k;
      if (em[c]) return c;
    end
    return -1;
  endfunction

  function automatic int next_pos(input int p, input logic [7:0] em, input int n, input bit d);
    for (int k = 1; k <= n; k++) begin
      int c;
      c = d ? ((p - k + n) % n) : ((p + k) % n);
      if (em[c]) return c;
    end
    return p;
  endfunction

  // Expected outputs after the coming clock edge, given the inputs now driven.
  task automatic model(input int idx, input int n);
    logic [7:0] em;
    exp_t       e;
    int         k;
    bit         fd;
    em = digit_mask & 8'((32'd1 << n) - 32'd1);
    if (reset) begin
      left[idx] = 0;
      pos[idx]  = 0;
      scan[idx] = 0;
      e = '{sel: 3'd0, en_n: 1'b1, fd: 1'b0, busy: 1'b0};
    end else if (left[idx] > 0) begin
      k = P - left[idx];
      left[idx]--;
      e = '{sel: 3'(pos[idx]), en_n: (k < B), fd: 1'b0, busy: 1'b1};
    end else begin
      fd = scan[idx] && (em != 0) && (pos[idx] == first_pos(em, n, !dir));
      if (run && (em != 0)) begin
        pos[idx]  = scan[idx] ? next_pos(pos[idx], em, n, dir) : first_pos(em, n, dir);
        left[idx] = P - 1;
        scan[idx] = 1;
        e = '{sel: 3'(pos[idx]), en_n: 1'b1, fd: fd, busy: 1'b1};
      end else begin
        scan[idx] = 0;
        e = '{sel: 3'(pos[idx]), en_n: 1'b1, fd: fd, busy: 1'b0};
      end
    end
    if (idx == 0) q8.push_back(e);
    else          q5.push_back(e);
  endtask

  task automatic step(input bit r, input bit rn, input logic [7:0] m);
    reset      = r;
    run        = rn;
    digit_mask = m;
`ifdef SCAN_REVERSE_EN
    if ($urandom_range(0, 3) == 0) dir = 1'($urandom_range(0, 1));
`endif
    model(0, 8);
    model(1, 5);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (q8.size() > 0) begin
        e = q8.pop_front();
        checks++;
        if ({sel8, en8, fd8, busy8} !== e) begin
          errors++;
          $display("FAIL u8 cyc %0d: got sel=%0d en_n=%b fd=%b busy=%b, want sel=%0d en_n=%b fd=%b busy=%b",
                   cyc, sel8, en8, fd8, busy8, e.sel, e.en_n, e.fd, e.busy);
        end
      end
      if (q5.size() > 0) begin
        e = q5.pop_front();
        checks++;
        if ({sel5, en5, fd5, busy5} !== e) begin
          errors++;
          $display("FAIL u5 cyc %0d: got sel=%0d en_n=%b fd=%b busy=%b, want sel=%0d en_n=%b fd=%b busy=%b",
                   cyc, sel5, en5, fd5, busy5, e.sel, e.en_n, e.fd, e.busy);
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] m;
    bit         rn;
    // reset held, then idle with run low
    repeat (3) step(1, 0, 8'hFF);
    repeat (4) step(0, 0, 8'hFF);
    // full scan, two frames, then reset lands on the 2nd ACTIVE cycle of sel=6
    repeat (96) step(0, 1, 8'hFF);
    repeat (3) step(1, 0, 8'hFF);
    repeat (40) step(0, 1, 8'hFF);
    step(1, 1, 8'hFF);
    repeat (3) step(0, 0, 8'hFF);
    // two-position scan
    repeat (30) step(0, 1, 8'b0010_0100);
    // run dropped mid-dwell of sel=3
    step(1, 0, 8'hFF);
    repeat (21) step(0, 1, 8'hFF);
    repeat (10) step(0, 0, 8'hFF);
    // empty mask never leaves idle
    repeat (20) step(0, 1, 8'h00);
    // single position re-selects itself
    repeat (20) step(0, 1, 8'b0001_0000);
    // randomized traffic with mid-position mask changes
    m  = 8'hFF;
    rn = 1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: m = 8'($urandom);
          1: m = 8'(1 << $urandom_range(0, 7));
          2: m = 8'($urandom) & 8'($urandom);
          default: m = 8'hE0 | 8'($urandom_range(0, 3));
        endcase
      end
      if ($urandom_range(0, 15) == 0) rn = ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 299) == 0, rn, m);
    end
    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
